multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter OPW, default 3, meaning opcode width; values at or above 8 are illegal opcodes.
REQ-002 SHALL have parameter FNW, default 4, meaning func width.
REQ-003 SHALL have parameter TMO, default 15, meaning the maximum number of cycles spent waiting on mem_ready before timeout.
REQ-004 CLK  in  1  rising-edge clock.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 opcode  in  OPW  instruction opcode; valid in DECODE.
REQ-007 func  in  FNW  instruction function field; valid in DECODE.
REQ-008 mem_ready  in  1  memory access complete this cycle.
REQ-009 stall  in  1  external freeze request.
REQ-010 PCWrite, IRWrite, RegWrite, MemRead, MemWrite, Branch, JumpOut, ALUsrc  out  1 each  datapath controls.
REQ-011 ALUop  out  3  ALU operation code.
REQ-012 RegStore  out  2  writeback source: 0 memory, 1 ALU, 2 link.
REQ-013 state_out  out  3  current state encoding.
REQ-014 illegal  out  1  one-cycle pulse on an illegal opcode.
REQ-015 mem_timeout  out  1  sticky timeout flag.

Function
REQ-016 SHALL implement the Moore FSM FETCH(0), DECODE(1), EXEC(2), MEM(3), WB(4); encodings 5-7 SHALL go to FETCH.
REQ-017 In FETCH: MemRead=1; on mem_ready, PCWrite=1 and IRWrite=1 (combinational in the same cycle), then go to DECODE; otherwise hold.
REQ-018 In DECODE: latch opcode and func into internal registers, then go to EXEC.
REQ-019 Instruction classes in EXEC:
- 0 (R-type): ALUsrc=1; func 0/1/2/3 gives ALUop 1/2/3/4.
- 1 (I-type): ALUsrc=0; func 0/1/2/3 gives ALUop 1/5/6/7.
- 2 (LW) and 3 (SW): ALUop=1.
- 4 and 5 (branch): ALUop=2.
- 6 (jump-in) and 7 (jump-out): ALUop=0.
REQ-020 An undefined func on R-type or I-type SHALL give ALUop=0; ALUop and all controls SHALL be fully specified in every state, with no latches.
REQ-021 EXEC transitions:
- R-type and I-type go to WB.
- LW and SW go to MEM.
- Branch asserts Branch=1 for one cycle and goes to FETCH.
- Opcode 6 asserts Branch=1 and goes to WB.
- Opcode 7 asserts Branch=1 and JumpOut=1 and goes to FETCH.
REQ-022 In MEM: LW asserts MemRead=1, SW asserts MemWrite=1, both held until mem_ready; then LW goes to WB and SW goes to FETCH.
REQ-023 In WB: RegWrite=1 for one cycle, then go to FETCH; RegStore is 1 for R/I, 0 for LW, and 2 for opcode 6.
REQ-024 Illegal opcode (OPW>3 and latched value at or above 8): illegal=1 for one cycle in EXEC, no strobes asserted, next state FETCH.
REQ-025 Latency with zero-wait memory:
- R/I: 4 cycles.
- LW: 5 cycles.
- SW and opcode 6: 4 cycles.
- Branch and opcode 7: 3 cycles.
REQ-026 stall=1 SHALL hold the state and the wait counter, and SHALL force PCWrite, IRWrite, RegWrite, MemWrite, Branch and JumpOut to 0; MemRead is unaffected.
REQ-027 When stall and mem_ready are both asserted, stall SHALL win and the access SHALL NOT complete.
REQ-028 A wait counter, log2(TMO+1) bits wide, SHALL count cycles in FETCH or MEM while mem_ready=0 and stall=0, and SHALL clear on every state change.
REQ-029 When the wait counter reaches TMO: set mem_timeout, deassert all strobes, go to FETCH next cycle, and do not advance the PC.
REQ-030 mem_timeout SHALL remain set until reset.

Reset
REQ-031 reset=1 SHALL, on the clock edge, load FETCH and clear the latched opcode/func, the wait counter, illegal and mem_timeout.
REQ-032 While reset=1, every output SHALL be 0, overriding the state decode, including MemRead and state_out.
REQ-033 Reset in mid-instruction (any state, including a pending MEM access) SHALL abandon the instruction with no strobe asserted in that cycle.

Structure
REQ-034 Package misc_v_ctrl_pkg SHALL hold the state enum, the opcode class constants (0-7), the ALUop constants (0-7) and the RegStore constants.
REQ-035 Sub-module ctrl_decode SHALL map the latched opcode/func to class, ALUop and ALUsrc combinationally; the FSM, counter and flags SHALL stay in multicycle_control.

Verification
REQ-036 Reset then R-type add (op0, fn0), mem_ready tied high -> states 0,1,2,4; ALUsrc=1 and ALUop=1 in EXEC; RegWrite=1 and RegStore=1 in cycle 4 only.
REQ-037 LW (op2) with mem_ready low for 3 MEM cycles -> MemRead held 4 MEM cycles, then WB with RegStore=0; SW (op3) -> MemWrite=1, returns to FETCH, RegWrite never 1.
REQ-038 Branch op4 / jump-out op7 -> Branch=1 for exactly one cycle (op7 also JumpOut=1), then FETCH; op6 -> Branch then WB with RegStore=2.
REQ-039 stall=1 together with mem_ready=1 in FETCH for 2 cycles -> state stays 0 and PCWrite/IRWrite stay 0; after stall drops, completes normally.
REQ-040 mem_ready held low in MEM with TMO=15 -> mem_timeout rises after 15 wait cycles, state goes to 0, flag stays set until reset.
REQ-041 reset asserted during MEM of a SW -> MemWrite=0 in that cycle, FETCH next, all flags cleared; OPW=4 with op9 -> illegal pulse, no strobes.

Source files
------------

// File: rtl/misc_v_ctrl_pkg.sv
// Shared types and constants for the multicycle controller: state encoding,
// instruction classes, ALU operation codes and writeback source selects.
package misc_v_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_e;

   localparam logic [2:0] CLS_RTYPE = 3'd0;
   localparam logic [2:0] CLS_ITYPE = 3'd1;
   localparam logic [2:0] CLS_LW    = 3'd2;
   localparam logic [2:0] CLS_SW    = 3'd3;
   localparam logic [2:0] CLS_BEQ   = 3'd4;
   localparam logic [2:0] CLS_BNE   = 3'd5;
   localparam logic [2:0] CLS_JIN   = 3'd6;
   localparam logic [2:0] CLS_JOUT  = 3'd7;

   localparam logic [2:0] ALU_NOP = 3'd0;
   localparam logic [2:0] ALU_ADD = 3'd1;
   localparam logic [2:0] ALU_SUB = 3'd2;
   localparam logic [2:0] ALU_AND = 3'd3;
   localparam logic [2:0] ALU_OR  = 3'd4;
   localparam logic [2:0] ALU_XOR = 3'd5;
   localparam logic [2:0] ALU_SLT = 3'd6;
   localparam logic [2:0] ALU_SHL = 3'd7;

   localparam logic [1:0] RS_MEM  = 2'd0;
   localparam logic [1:0] RS_ALU  = 2'd1;
   localparam logic [1:0] RS_LINK = 2'd2;

endpackage

// File: rtl/multicycle_control_decode.sv
// Purely combinational instruction decode: latched opcode/func to class,
// ALU operation and ALU source select.
import misc_v_ctrl_pkg::*;

module ctrl_decode #(
   parameter int OPW = 3,
   parameter int FNW = 4
) (
   input  logic [OPW-1:0] op,
   input  logic [FNW-1:0] fn,
   output logic [2:0]     op_class,
   output logic           op_illegal,
   output logic [2:0]     alu_op,
   output logic           alu_src
);

   logic       fn_defined;
   logic [1:0] fn_sel;

   // Only func values 0-3 are defined; anything with upper bits set maps to ALU_NOP.
   always_comb begin
      op_class   = op[2:0];
      op_illegal = (op >> 3) != '0;
      fn_defined = (fn >> 2) == '0;
      fn_sel     = fn[1:0];
      alu_op     = ALU_NOP;
      alu_src    = 1'b0;
      if (!op_illegal) begin
         case (op_class)
            CLS_RTYPE: begin
               alu_src = 1'b1;
               if (fn_defined) begin
                  case (fn_sel)
                     2'd0: alu_op = ALU_ADD;
                     2'd1: alu_op = ALU_SUB;
                     2'd2: alu_op = ALU_AND;
                     2'd3: alu_op = ALU_OR;
                  endcase
               end
            end
            CLS_ITYPE: begin
               if (fn_defined) begin
                  case (fn_sel)
                     2'd0: alu_op = ALU_ADD;
                     2'd1: alu_op = ALU_XOR;
                     2'd2: alu_op = ALU_SLT;
                     2'd3: alu_op = ALU_SHL;
                  endcase
               end
            end
            CLS_LW, CLS_SW:   alu_op = ALU_ADD;
            CLS_BEQ, CLS_BNE: alu_op = ALU_SUB;
            default:          alu_op = ALU_NOP;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control FSM with memory wait counter, sticky timeout
// flag, external stall and illegal-opcode detection.
import misc_v_ctrl_pkg::*;

module multicycle_control #(
   parameter int OPW = 3,
   parameter int FNW = 4,
   parameter int TMO = 15
) (
   input  logic           CLK,
   input  logic           reset,
   input  logic [OPW-1:0] opcode,
   input  logic [FNW-1:0] func,
   input  logic           mem_ready,
   input  logic           stall,
   output logic           PCWrite,
   output logic           IRWrite,
   output logic           RegWrite,
   output logic           MemRead,
   output logic           MemWrite,
   output logic           Branch,
   output logic           JumpOut,
   output logic           ALUsrc,
   output logic [2:0]     ALUop,
   output logic [1:0]     RegStore,
   output logic [2:0]     state_out,
   output logic           illegal,
   output logic           mem_timeout
);

   localparam int            CW      = (TMO < 1) ? 1 : $clog2(TMO + 1);
   localparam logic [CW-1:0] TMO_CNT = CW'(TMO);

   state_e         state_q, state_d;
   logic [OPW-1:0] op_q, op_d;
   logic [FNW-1:0] fn_q, fn_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           timeout_q, timeout_d;

   logic [2:0] op_class;
   logic       op_illegal;
   logic [2:0] dec_alu_op;
   logic       dec_alu_src;
   logic       waiting;
   logic       timed_out;

   ctrl_decode #(
      .OPW(OPW),
      .FNW(FNW)
   ) u_decode (
      .op        (op_q),
      .fn        (fn_q),
      .op_class  (op_class),
      .op_illegal(op_illegal),
      .alu_op    (dec_alu_op),
      .alu_src   (dec_alu_src)
   );

   // A stalled cycle never counts as waiting time, so it can never trip the timeout.
   assign waiting   = (state_q == S_FETCH) || (state_q == S_MEM);
   assign timed_out = waiting && (cnt_q == TMO_CNT) && !stall;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      fn_d      = fn_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      if (reset) begin
         state_d   = S_FETCH;
         op_d      = '0;
         fn_d      = '0;
         cnt_d     = '0;
         timeout_d = 1'b0;
      end else if (!stall) begin
         if (timed_out) begin
            state_d   = S_FETCH;
            timeout_d = 1'b1;
         end else begin
            case (state_q)
               S_FETCH: if (mem_ready) state_d = S_DECODE;
               S_DECODE: begin
                  state_d = S_EXEC;
                  op_d    = opcode;
                  fn_d    = func;
               end
               S_EXEC: begin
                  if (op_illegal) state_d = S_FETCH;
                  else begin
                     case (op_class)
                        CLS_RTYPE, CLS_ITYPE, CLS_JIN: state_d = S_WB;
                        CLS_LW, CLS_SW:                state_d = S_MEM;
                        default:                       state_d = S_FETCH;
                     endcase
                  end
               end
               S_MEM: if (mem_ready) state_d = (op_class == CLS_LW) ? S_WB : S_FETCH;
               default: state_d = S_FETCH;
            endcase
         end
         // A timeout from FETCH stays in FETCH, so it must clear the counter explicitly.
         if (timed_out || (state_d != state_q)) cnt_d = '0;
         else if (waiting && !mem_ready)       cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      state_q   <= state_d;
      op_q      <= op_d;
      fn_q      <= fn_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
   end

   // Reset overrides the whole decode; stall gates every strobe except MemRead.
   always_comb begin
      PCWrite     = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      Branch      = 1'b0;
      JumpOut     = 1'b0;
      ALUsrc      = 1'b0;
      ALUop       = ALU_NOP;
      RegStore    = RS_MEM;
      state_out   = 3'd0;
      illegal     = 1'b0;
      mem_timeout = 1'b0;
      if (!reset) begin
         state_out   = state_q;
         mem_timeout = timeout_q;
         case (state_q)
            S_FETCH: begin
               if (!timed_out) begin
                  MemRead = 1'b1;
                  PCWrite = mem_ready && !stall;
                  IRWrite = mem_ready && !stall;
               end
            end
            S_EXEC: begin
               ALUop  = dec_alu_op;
               ALUsrc = dec_alu_src;
               if (op_illegal) illegal = !stall;
               else begin
                  case (op_class)
                     CLS_BEQ, CLS_BNE, CLS_JIN: Branch = !stall;
                     CLS_JOUT: begin
                        Branch  = !stall;
                        JumpOut = !stall;
                     end
                     default: ;
                  endcase
               end
            end
            S_MEM: begin
               if (!timed_out) begin
                  MemRead  = (op_class == CLS_LW);
                  MemWrite = (op_class == CLS_SW) && !stall;
               end
            end
            S_WB: begin
               RegWrite = !stall;
               case (op_class)
                  CLS_RTYPE, CLS_ITYPE: RegStore = RS_ALU;
                  CLS_JIN:              RegStore = RS_LINK;
                  default:              RegStore = RS_MEM;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Scenario bench for multicycle_control: per-cycle stimulus rows carry the
// expected output vector, which is queued as driven and checked at negedge.
module tb_multicycle_control;

   logic       CLK;
   logic       reset;
   logic [3:0] opcode;
   logic [3:0] func;
   logic       mem_ready;
   logic       stall;
   logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite, Branch, JumpOut, ALUsrc;
   logic [2:0] ALUop;
   logic [1:0] RegStore;
   logic [2:0] state_out;
   logic       illegal;
   logic       mem_timeout;

   int total = 0;
   int bad   = 0;

   localparam logic [7:0] PCW  = 8'h80;
   localparam logic [7:0] IRW  = 8'h40;
   localparam logic [7:0] RGW  = 8'h20;
   localparam logic [7:0] MRD  = 8'h10;
   localparam logic [7:0] MWR  = 8'h08;
   localparam logic [7:0] BRN  = 8'h04;
   localparam logic [7:0] JMP  = 8'h02;
   localparam logic [7:0] ASR  = 8'h01;
   localparam logic [7:0] NONE = 8'h00;
   localparam logic [3:0] XX   = 4'hF;

   typedef struct {
      logic [95:0] tag;
      logic [17:0] v;
      logic [17:0] m;
   } exp_t;

   typedef struct {
      logic       rst;
      logic [3:0] op;
      logic [3:0] fn;
      logic       rdy;
      logic       stl;
      exp_t       e;
   } stim_t;

   stim_t sq[$];
   exp_t  sb[$];

   multicycle_control #(
      .OPW(4),
      .FNW(4),
      .TMO(15)
   ) dut (
      .CLK        (CLK),
      .reset      (reset),
      .opcode     (opcode),
      .func       (func),
      .mem_ready  (mem_ready),
      .stall      (stall),
      .PCWrite    (PCWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .Branch     (Branch),
      .JumpOut    (JumpOut),
      .ALUsrc     (ALUsrc),
      .ALUop      (ALUop),
      .RegStore   (RegStore),
      .state_out  (state_out),
      .illegal    (illegal),
      .mem_timeout(mem_timeout)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   // Vector layout: {state[2:0], PCW,IRW,RGW,MRD,MWR,BRN,JMP,ASR, ALUop[2:0], RegStore[1:0], illegal, mem_timeout}
   function automatic logic [17:0] observed();
      return {state_out, PCWrite, IRWrite, RegWrite, MemRead, MemWrite, Branch, JumpOut,
              ALUsrc, ALUop, RegStore, illegal, mem_timeout};
   endfunction

   // ALUop/ALUsrc are only checked in EXEC and RegStore only in WB, where their values are defined.
   function automatic exp_t ex(input logic [95:0] tag, input logic [2:0] st, input logic [7:0] strb,
                               input logic [2:0] aop, input logic [1:0] rs, input logic il,
                               input logic to, input bit chk_as = 1'b1, input bit chk_aop = 1'b1);
      exp_t e;
      e.tag = tag;
      e.v   = {st, strb, aop, rs, il, to};
      e.m   = '1;
      if (st != 3'd2) e.m[7:4] = '0;
      if (st != 3'd4) e.m[3:2] = '0;
      if (!chk_as)  e.m[7]   = 1'b0;
      if (!chk_aop) e.m[6:4] = '0;
      return e;
   endfunction

   function automatic exp_t ez(input logic [95:0] tag);
      exp_t e;
      e.tag = tag;
      e.v   = '0;
      e.m   = '1;
      return e;
   endfunction

   task automatic add(input logic rst, input logic [3:0] op, input logic [3:0] fn,
                      input logic rdy, input logic stl, input exp_t e);
      stim_t s;
      s.rst = rst;
      s.op  = op;
      s.fn  = fn;
      s.rdy = rdy;
      s.stl = stl;
      s.e   = e;
      sq.push_back(s);
   endtask

   task automatic drive(input stim_t s);
      reset     = s.rst;
      opcode    = s.op;
      func      = s.fn;
      mem_ready = s.rdy;
      stall     = s.stl;
      sb.push_back(s.e);
   endtask

   task automatic test_reset();
      stim_t s;
      exp_t  e;
      logic [17:0] got;
      add(1, XX, XX, 1, 0, ez("rst0"));
      add(1, XX, XX, 1, 1, ez("rst1"));
      add(1, 4'd2, 4'd0, 0, 0, ez("rst2"));
      while (sq.size() > 0) begin
         s = sq.pop_front();
         drive(s);
         @(negedge CLK);
         e = sb.pop_front();
         got = observed();
         total++;
         if ((got & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("[TB] FAIL %0s: got %b want %b mask %b", e.tag, got, e.v, e.m);
         end
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_alu_ops();
      stim_t s;
      exp_t  e;
      logic [17:0] got;
      add(0, XX, XX, 1, 0, ex("rt_fetch", 3'd0, PCW | IRW | MRD, 0, 0, 0, 0));
      add(0, 4'd0, 4'd0, 1, 0, ex("rt_decode", 3'd1, NONE, 0, 0, 0, 0));
      add(0, XX, XX, 1, 0, ex("rt_exec", 3'd2, ASR, 3'd1, 0, 0, 0));
      add(0, XX, XX, 1, 0, ex("rt_wb", 3'd4, RGW, 0, 2'd1, 0, 0));
      add(0, XX, XX, 1, 0, ex("it_fetch", 3'd0, PCW | IRW | MRD, 0, 0, 0, 0));
      add(0, 4'd1, 4'd3, 1, 0, ex("it_decode", 3'd1, NONE, 0, 0, 0, 0));
      add(0, XX, XX, 1, 0, ex("it_exec", 3'd2, NONE, 3'd7, 0, 0, 0));
      add(0, XX, XX, 1, 0, ex("it_wb", 3'd4, RGW, 0, 2'd1, 0, 0));
      add(0, XX, XX, 1, 0, ex("iu_fetch", 3'd0, PCW | IRW | MRD, 0, 0, 0, 0));
      add(0, 4'd1, 4'd4, 1, 0, ex("iu_decode", 3'd1, NONE, 0, 0, 0, 0));
      add(0, XX, XX, 1, 0, ex("iu_exec", 3'd2, NONE, 3'd0, 0, 0, 0));
      add(0, XX, XX, 1, 0, ex("iu_wb", 3'd4, RGW, 0, 2'd1, 0, 0));
      add(0, XX, XX, 1, 0, ex("ra_fetch", 3'd0, PCW | IRW | MRD, 0, 0, 0, 0));
      add(0, 4'd0, 4'd2, 1, 0, ex("ra_decode", 3'd1, NONE, 0, 0, 0, 0));
      add(0, XX, XX, 1, 0, ex("ra_exec", 3'd2, ASR, 3'd3, 0, 0, 0));
      add(0, XX, XX, 1, 0, ex("ra_wb", 3'd4, RGW, 0, 2'd1, 0, 0));
      while (sq.size() > 0) begin
         s = sq.pop_front();
         drive(s);
         @(negedge CLK);
         e = sb.pop_front();
         got = observed();
         total++;
         if ((got & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("[TB] FAIL %0s: got %b want %b mask %b", e.tag, got, e.v, e.m);
         end
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_lw_sw();
      stim_t s;
      exp_t  e;
      logic [17:0] got;
      add(0, XX, XX, 1, 0, ex("lw_fetch", 3'd0, PCW | IRW | MRD, 0, 0, 0, 0));
      add(0, 4'd2, 4'd0, 1, 0, ex("lw_decode", 3'd1, NONE, 0, 0, 0, 0));
      add(0, XX, XX, 1, 0, ex("lw_exec", 3'd2, NONE, 3'd1, 0, 0, 0, 1'b0));
      for (int i = 0; i < 3; i++) add(0, XX, XX, 0, 0, ex("lw_memwait", 3'd3, MRD, 0, 0, 0, 0));
      add(0, XX, XX, 1, 0, ex("lw_memdone", 3'd3, MRD, 0, 0, 0, 0));
      add(0, XX, XX, 1, 0, ex("lw_wb", 3'd4, RGW, 0, 2'd0, 0, 0));
      add(0, XX, XX, 1, 0, ex("sw_fetch", 3'd0, PCW | IRW | MRD, 0, 0, 0, 0));
      add(0, 4'd3, 4'd0, 1, 0, ex("sw_decode", 3'd1, NONE, 0, 0, 0, 0));
      add(0, XX, XX, 1, 0, ex("sw_exec", 3'd2, NONE, 3'd1, 0, 0, 0, 1'b0));
      add(0, XX, XX, 1, 0, ex("sw_mem", 3'd3, MWR, 0, 0, 0, 0));
      add(0, XX, XX, 0, 0, ex("sw_return", 3'd0, MRD, 0, 0, 0, 0));
      while (sq.size() > 0) begin
         s = sq.pop_front();
         drive(s);
         @(negedge CLK);
         e = sb.pop_front();
         got = observed();
         total++;
         if ((got & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("[TB] FAIL %0s: got %b want %b mask %b", e.tag, got, e.v, e.m);
         end
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_branch_jump();
      stim_t s;
      exp_t  e;
      logic [17:0] got;
      add(0, XX, XX, 1, 0, ex("br_fetch", 3'd0, PCW | IRW | MRD, 0, 0, 0, 0));
      add(0, 4'd4, 4'd0, 1, 0, ex("br_decode", 3'd1, NONE, 0, 0, 0, 0));
      add(0, XX, XX, 1, 0, ex("br_exec", 3'd2, BRN, 3'd2, 0, 0, 0, 1'b0));
      add(0, XX, XX, 0, 0, ex("br_return", 3'd0, MRD, 0, 0, 0, 0));
      add(0, XX, XX, 1, 0, ex("jo_fetch", 3'd0, PCW | IRW | MRD, 0, 0, 0, 0));
      add(0, 4'd7, 4'd0, 1, 0, ex("jo_decode", 3'd1, NONE, 0, 0, 0, 0));
      add(0, XX, XX, 1, 0, ex("jo_exec", 3'd2, BRN | JMP, 3'd0, 0, 0, 0, 1'b0));
      add(0, XX, XX, 1, 0, ex("jo_return", 3'd0, PCW | IRW | MRD, 0, 0, 0, 0));
      add(0, 4'd6, 4'd0, 1, 0, ex("ji_decode", 3'd1, NONE, 0, 0, 0, 0));
      add(0, XX, XX, 1, 0, ex("ji_exec", 3'd2, BRN, 3'd0, 0, 0, 0, 1'b0));
      add(0, XX, XX, 1, 0, ex("ji_wb", 3'd4, RGW, 0, 2'd2, 0, 0));
      add(0, XX, XX, 1, 0, ex("bn_fetch", 3'd0, PCW | IRW | MRD, 0, 0, 0, 0));
      add(0, 4'd5, 4'd0, 1, 0, ex("bn_decode", 3'd1, NONE, 0, 0, 0, 0));
      add(0, XX, XX, 1, 0, ex("bn_exec", 3'd2, BRN, 3'd2, 0, 0, 0, 1'b0));
      while (sq.size() > 0) begin
         s = sq.pop_front();
         drive(s);
         @(negedge CLK);
         e = sb.pop_front();
         got = observed();
         total++;
         if ((got & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("[TB] FAIL %0s: got %b want %b mask %b", e.tag, got, e.v, e.m);
         end
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_stall();
      stim_t s;
      exp_t  e;
      logic [17:0] got;
      add(0, XX, XX, 1, 1, ex("st_fetch0", 3'd0, MRD, 0, 0, 0, 0));
      add(0, XX, XX, 1, 1, ex("st_fetch1", 3'd0, MRD, 0, 0, 0, 0));
      add(0, XX, XX, 1, 0, ex("st_fetch2", 3'd0, PCW | IRW | MRD, 0, 0, 0, 0));
      add(0, 4'd0, 4'd1, 1, 0, ex("st_decode", 3'd1, NONE, 0, 0, 0, 0));
      add(0, XX, XX, 1, 1, ex("st_exec0", 3'd2, ASR, 3'd2, 0, 0, 0));
      add(0, XX, XX, 1, 0, ex("st_exec1", 3'd2, ASR, 3'd2, 0, 0, 0));
      add(0, XX, XX, 1, 1, ex("st_wb0", 3'd4, NONE, 0, 2'd1, 0, 0));
      add(0, XX, XX, 1, 0, ex("st_wb1", 3'd4, RGW, 0, 2'd1, 0, 0));
      add(0, XX, XX, 1, 0, ex("st_swfetch", 3'd0, PCW | IRW | MRD, 0, 0, 0, 0));
      add(0, 4'd3, 4'd0, 1, 0, ex("st_swdecode", 3'd1, NONE, 0, 0, 0, 0));
      add(0, XX, XX, 1, 0, ex("st_swexec", 3'd2, NONE, 3'd1, 0, 0, 0, 1'b0));
      add(0, XX, XX, 1, 1, ex("st_swmem0", 3'd3, NONE, 0, 0, 0, 0));
      add(0, XX, XX, 1, 0, ex("st_swmem1", 3'd3, MWR, 0, 0, 0, 0));
      while (sq.size() > 0) begin
         s = sq.pop_front();
         drive(s);
         @(negedge CLK);
         e = sb.pop_front();
         got = observed();
         total++;
         if ((got & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("[TB] FAIL %0s: got %b want %b mask %b", e.tag, got, e.v, e.m);
         end
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_timeout();
      stim_t s;
      exp_t  e;
      logic [17:0] got;
      add(0, XX, XX, 1, 0, ex("to_fetch", 3'd0, PCW | IRW | MRD, 0, 0, 0, 0));
      add(0, 4'd2, 4'd0, 1, 0, ex("to_decode", 3'd1, NONE, 0, 0, 0, 0));
      add(0, XX, XX, 1, 0, ex("to_exec", 3'd2, NONE, 3'd1, 0, 0, 0, 1'b0));
      for (int i = 0; i < 15; i++) add(0, XX, XX, 0, 0, ex("to_wait", 3'd3, MRD, 0, 0, 0, 0));
      add(0, XX, XX, 0, 0, ex("to_fire", 3'd3, NONE, 0, 0, 0, 0));
      add(0, XX, XX, 0, 0, ex("to_flagset", 3'd0, MRD, 0, 0, 0, 1));
      add(0, XX, XX, 1, 0, ex("to_sticky_f", 3'd0, PCW | IRW | MRD, 0, 0, 0, 1));
      add(0, 4'd4, 4'd0, 1, 0, ex("to_sticky_d", 3'd1, NONE, 0, 0, 0, 1));
      add(0, XX, XX, 1, 0, ex("to_sticky_e", 3'd2, BRN, 3'd2, 0, 0, 1, 1'b0));
      while (sq.size() > 0) begin
         s = sq.pop_front();
         drive(s);
         @(negedge CLK);
         e = sb.pop_front();
         got = observed();
         total++;
         if ((got & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("[TB] FAIL %0s: got %b want %b mask %b", e.tag, got, e.v, e.m);
         end
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_reset_mid_mem();
      stim_t s;
      exp_t  e;
      logic [17:0] got;
      add(0, XX, XX, 1, 0, ex("rm_fetch", 3'd0, PCW | IRW | MRD, 0, 0, 0, 1));
      add(0, 4'd3, 4'd0, 1, 0, ex("rm_decode", 3'd1, NONE, 0, 0, 0, 1));
      add(0, XX, XX, 1, 0, ex("rm_exec", 3'd2, NONE, 3'd1, 0, 0, 1, 1'b0));
      add(0, XX, XX, 0, 0, ex("rm_mem", 3'd3, MWR, 0, 0, 0, 1));
      add(1, XX, XX, 1, 0, ez("rm_reset"));
      add(0, XX, XX, 0, 0, ex("rm_after", 3'd0, MRD, 0, 0, 0, 0));
      while (sq.size() > 0) begin
         s = sq.pop_front();
         drive(s);
         @(negedge CLK);
         e = sb.pop_front();
         got = observed();
         total++;
         if ((got & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("[TB] FAIL %0s: got %b want %b mask %b", e.tag, got, e.v, e.m);
         end
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_illegal();
      stim_t s;
      exp_t  e;
      logic [17:0] got;
      add(0, XX, XX, 1, 0, ex("il_fetch", 3'd0, PCW | IRW | MRD, 0, 0, 0, 0));
      add(0, 4'd9, 4'd0, 1, 0, ex("il_decode", 3'd1, NONE, 0, 0, 0, 0));
      add(0, XX, XX, 1, 0, ex("il_exec", 3'd2, NONE, 0, 0, 1, 0, 1'b0, 1'b0));
      add(0, XX, XX, 0, 0, ex("il_return", 3'd0, MRD, 0, 0, 0, 0));
      while (sq.size() > 0) begin
         s = sq.pop_front();
         drive(s);
         @(negedge CLK);
         e = sb.pop_front();
         got = observed();
         total++;
         if ((got & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("[TB] FAIL %0s: got %b want %b mask %b", e.tag, got, e.v, e.m);
         end
         @(posedge CLK);
         #1;
      end
   endtask

   initial begin
      test_reset();
      test_alu_ops();
      test_lw_sw();
      test_branch_jump();
      test_stall();
      test_timeout();
      test_reset_mid_mem();
      test_illegal();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
